// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column strobe, samples the
// synchronized rows at the end of each dwell, and locks onto a found key until release.
module keypad_scanner #(
  parameter int unsigned SCAN_CYCLES    = 12000,
  parameter int unsigned RELEASE_CYCLES = 4
) (
  input  logic       int_osc,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic       pressed,
  output logic [3:0] itemp
);

  localparam int unsigned DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int unsigned RW = (RELEASE_CYCLES > 0) ? $clog2(RELEASE_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
  localparam logic [RW-1:0] REL_LAST   = RW'(RELEASE_CYCLES);

  typedef enum logic {
    SCAN,
    HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    rows_m_q, rows_s_q;
  logic [3:0]    cols_q, cols_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [RW-1:0] rel_q, rel_d;
  logic          pressed_q, pressed_d;
  logic [3:0]    itemp_q, itemp_d;

  logic          scan_end;
  logic          key_seen;
  logic          released;
  logic [1:0]    col_idx;
  logic [1:0]    row_idx;
  logic [3:0]    cols_next;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  assign scan_end  = (state_q == SCAN) && (dwell_q == DWELL_LAST);
  assign key_seen  = (rows_s_q != 4'hF);
  assign released  = (state_q == HOLD) && (rel_q == REL_LAST);
  assign cols_next = {cols_q[2:0], cols_q[3]};

  always_comb begin
    case (cols_q)
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  // Lowest-index low row wins when several keys share the column.
  always_comb begin
    if (!rows_s_q[0])      row_idx = 2'd0;
    else if (!rows_s_q[1]) row_idx = 2'd1;
    else if (!rows_s_q[2]) row_idx = 2'd2;
    else                   row_idx = 2'd3;
  end

  always_ff @(posedge int_osc) begin
    if (reset) state_q <= SCAN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SCAN:    if (scan_end && key_seen) state_d = HOLD;
      HOLD:    if (released)             state_d = SCAN;
      default: state_d = SCAN;
    endcase
  end

  always_comb begin
    cols_d    = cols_q;
    dwell_d   = dwell_q;
    rel_d     = rel_q;
    pressed_d = pressed_q;
    itemp_d   = itemp_q;
    case (state_q)
      SCAN: begin
        rel_d = '0;
        if (!scan_end) begin
          dwell_d = dwell_q + 1'b1;
        end else begin
          dwell_d = '0;
          if (key_seen) begin
            pressed_d = 1'b1;
            itemp_d   = key_code(row_idx, col_idx);
          end else begin
            cols_d = cols_next;
          end
        end
      end
      HOLD: begin
        dwell_d = '0;
        if (released) begin
          pressed_d = 1'b0;
          cols_d    = cols_next;
          rel_d     = '0;
        end else if (key_seen) begin
          rel_d = '0;
        end else begin
          rel_d = rel_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge int_osc) begin
    if (reset) begin
      rows_m_q  <= 4'hF;
      rows_s_q  <= 4'hF;
      cols_q    <= 4'b1110;
      dwell_q   <= '0;
      rel_q     <= '0;
      pressed_q <= 1'b0;
      itemp_q   <= 4'h0;
    end else begin
      rows_m_q  <= rows;
      rows_s_q  <= rows_m_q;
      cols_q    <= cols_d;
      dwell_q   <= dwell_d;
      rel_q     <= rel_d;
      pressed_q <= pressed_d;
      itemp_q   <= itemp_d;
    end
  end

  assign cols    = cols_q;
  assign pressed = pressed_q;
  assign itemp   = itemp_q;

endmodule
